rr_priority_encoder: RTL and testbench

Parametrised, registered N-to-log2(N) priority encoder with valid/ready output handshake and selectable fixed or round-robin priority. It replaces the plain combinational 8-to-3 encoder wherever a request vector must be turned into a stream of one-hot grants or indices, for example interrupt/request scanning ahead of a shared resource. Unlike the combinational encoder, it holds its result under backpressure, reports when no request or more than one request is present, and rotates priority so that no requester starves.

---
 rtl/enc_pkg.sv | 31 +++
 rtl/prio_scan.sv | 40 ++++
 rtl/rr_priority_encoder.sv | 88 ++++++++
 tb/tb_rr_priority_encoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the request encoders: priority-mode constants,
// FSM state encoding and small index arithmetic helpers.
package enc_pkg;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } enc_state_t;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int mod_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

   function automatic int mod_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) begin
         s = s - n;
      end
      return s;
   endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational circular priority search: first set req bit at or after
// start (wrapping modulo N), plus "more than one request" detection.
module prio_scan
   import enc_pkg::*;
#(
   parameter int N = 8,
   parameter int W = idx_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx,
   output logic         multi
);

   logic [N-1:0] rot;
   logic [W-1:0] off;

   // Rotate so that bit 0 of rot is the highest-priority position.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N; i++) begin
         rot[i] = req[mod_add(int'(start), i, N)];
      end
   end

   always_comb begin
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = W'(i);
         end
      end
   end

   assign found = |req;
   assign idx   = W'(mod_add(int'(start), int'(off), N));
   assign multi = ($countones(req) > 1);

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with valid/ready output and
// fixed or round-robin priority; holds its result under backpressure.
module rr_priority_encoder
   import enc_pkg::*;
#(
   parameter  int N     = 8,
   parameter  int RR_EN = PRIO_RR,
   localparam int W     = idx_width(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic         out_multi,
   input  logic         out_ready
);

   localparam bit RR = (RR_EN == PRIO_RR);

   enc_state_t   state;
   logic [W-1:0] ptr;
   logic [W-1:0] scan_start;
   logic         scan_found;
   logic [W-1:0] scan_idx;
   logic         scan_multi;
   logic         accept;

   assign accept = out_valid & out_ready;

   // The search in an acceptance cycle already skips past the accepted index.
   always_comb begin
      scan_start = ptr;
      if (RR && accept) begin
         scan_start = W'(mod_inc(int'(out_idx), N));
      end
   end

   prio_scan #(
      .N (N),
      .W (W)
   ) u_scan (
      .req   (req),
      .start (scan_start),
      .found (scan_found),
      .idx   (scan_idx),
      .multi (scan_multi)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_multi <= 1'b0;
         ptr       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (scan_found) begin
                  state     <= ST_HOLD;
                  out_valid <= 1'b1;
                  out_idx   <= scan_idx;
                  out_multi <= scan_multi;
               end
            end
            ST_HOLD: begin
               // Without out_ready the presented index is frozen, whatever req does.
               if (out_ready) begin
                  if (scan_found) begin
                     out_idx   <= scan_idx;
                     out_multi <= scan_multi;
                     ptr       <= scan_start;
                  end else begin
                     state     <= ST_IDLE;
                     out_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed scoreboard bench for rr_priority_encoder: three instances
// (N=8 round-robin, N=8 fixed, N=5 round-robin) driven one at a time.
module tb_rr_priority_encoder;

   localparam int D_RR8 = 0;
   localparam int D_FX8 = 1;
   localparam int D_RR5 = 2;

   typedef struct {
      int         dut;
      logic       valid;
      logic [2:0] idx;
      logic       multi;
      string      tag;
   } exp_t;

   logic clk = 1'b0;

   logic       rst_rr8 = 1'b1, rdy_rr8 = 1'b0;
   logic [7:0] req_rr8 = '0;
   logic       v_rr8, m_rr8;
   logic [2:0] i_rr8;

   logic       rst_fx8 = 1'b1, rdy_fx8 = 1'b0;
   logic [7:0] req_fx8 = '0;
   logic       v_fx8, m_fx8;
   logic [2:0] i_fx8;

   logic       rst_rr5 = 1'b1, rdy_rr5 = 1'b0;
   logic [4:0] req_rr5 = '0;
   logic       v_rr5, m_rr5;
   logic [2:0] i_rr5;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   rr_priority_encoder #(.N(8), .RR_EN(1)) dut_rr8 (
      .clk(clk), .rst(rst_rr8), .req(req_rr8),
      .out_valid(v_rr8), .out_idx(i_rr8), .out_multi(m_rr8), .out_ready(rdy_rr8)
   );

   rr_priority_encoder #(.N(8), .RR_EN(0)) dut_fx8 (
      .clk(clk), .rst(rst_fx8), .req(req_fx8),
      .out_valid(v_fx8), .out_idx(i_fx8), .out_multi(m_fx8), .out_ready(rdy_fx8)
   );

   rr_priority_encoder #(.N(5), .RR_EN(1)) dut_rr5 (
      .clk(clk), .rst(rst_rr5), .req(req_rr5),
      .out_valid(v_rr5), .out_idx(i_rr5), .out_multi(m_rr5), .out_ready(rdy_rr5)
   );

   task automatic applyStimulus(input int dut, input logic r, input logic [7:0] rq,
                                input logic rdy, input logic ev, input logic [2:0] ei,
                                input logic em, input string tag);
      exp_t e;
      case (dut)
         D_RR8: begin rst_rr8 = r; req_rr8 = rq; rdy_rr8 = rdy; end
         D_FX8: begin rst_fx8 = r; req_fx8 = rq; rdy_fx8 = rdy; end
         default: begin rst_rr5 = r; req_rr5 = rq[4:0]; rdy_rr5 = rdy; end
      endcase
      e.dut   = dut;
      e.valid = ev;
      e.idx   = ei;
      e.multi = em;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t       e;
      logic       av;
      logic [2:0] ai;
      logic       am;
      if (exp_q.size() == 0) begin
         n_assert++;
         n_fail++;
         $display("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
         return;
      end
      e = exp_q.pop_front();
      case (e.dut)
         D_RR8:   begin av = v_rr8; ai = i_rr8; am = m_rr8; end
         D_FX8:   begin av = v_fx8; ai = i_fx8; am = m_fx8; end
         default: begin av = v_rr5; ai = i_rr5; am = m_rr5; end
      endcase
      n_assert++;
      assert (av === e.valid) else begin
         n_fail++;
         $error("[TB] FAIL %s out_valid: observed %0b expected %0b", e.tag, av, e.valid);
      end
      n_assert++;
      assert (ai === e.idx) else begin
         n_fail++;
         $error("[TB] FAIL %s out_idx: observed %0d expected %0d", e.tag, ai, e.idx);
      end
      n_assert++;
      assert (am === e.multi) else begin
         n_fail++;
         $error("[TB] FAIL %s out_multi: observed %0b expected %0b", e.tag, am, e.multi);
      end
   endtask

   task automatic step(input int dut, input logic r, input logic [7:0] rq, input logic rdy,
                       input logic ev, input logic [2:0] ei, input logic em, input string tag);
      applyStimulus(dut, r, rq, rdy, ev, ei, em, tag);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed no completion, expected finish before 100000");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      $display("[TB] start");

      // Reset and idle, including out_ready asserted with no output pending
      step(D_RR8, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "rr8_reset");
      for (int k = 0; k < 5; k++) begin
         step(D_RR8, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, "idle");
      end

      // Round-robin sweep with all requests held
      for (int k = 0; k < 8; k++) begin
         step(D_RR8, 1'b0, 8'hFF, 1'b1, 1'b1, 3'(k), 1'b1, "rr_sweep");
      end
      step(D_RR8, 1'b0, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b1, "rr_sweep_wrap");

      // Backpressure: hold, ignore req changes, then wrap-around search
      step(D_RR8, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "bp_reset");
      step(D_RR8, 1'b0, 8'b0010_0100, 1'b0, 1'b1, 3'd2, 1'b1, "bp_capture");
      for (int k = 0; k < 3; k++) begin
         step(D_RR8, 1'b0, 8'b0010_0100, 1'b0, 1'b1, 3'd2, 1'b1, "bp_hold");
      end
      step(D_RR8, 1'b0, 8'h01, 1'b0, 1'b1, 3'd2, 1'b1, "bp_req_change");
      step(D_RR8, 1'b0, 8'h01, 1'b1, 1'b1, 3'd0, 1'b0, "bp_accept_wrap");
      step(D_RR8, 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "bp_new_hold");
      step(D_RR8, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, "bp_drain");

      // Reset while an index is presented and being accepted
      step(D_RR8, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "rst_reset");
      step(D_RR8, 1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "rst_cap5");
      step(D_RR8, 1'b0, 8'h40, 1'b1, 1'b1, 3'd6, 1'b0, "rst_accept5");
      step(D_RR8, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, "rst_wins");
      step(D_RR8, 1'b0, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b1, "rst_first_after");
      step(D_RR8, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "rr8_park");

      // Fixed priority: single request, then lowest index always wins
      step(D_FX8, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "fx_reset");
      step(D_FX8, 1'b0, 8'h80, 1'b1, 1'b1, 3'd7, 1'b0, "fx_single");
      for (int k = 0; k < 3; k++) begin
         step(D_FX8, 1'b0, 8'b0010_0100, 1'b1, 1'b1, 3'd2, 1'b1, "fx_repeat");
      end

      // N=5: pointer wraps from 4 to 0, indices never reach 5..7
      step(D_RR5, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "n5_reset");
      step(D_RR5, 1'b0, 8'h10, 1'b1, 1'b1, 3'd4, 1'b0, "n5_cap4");
      step(D_RR5, 1'b0, 8'h01, 1'b1, 1'b1, 3'd0, 1'b0, "n5_wrap");
      step(D_RR5, 1'b0, 8'h11, 1'b1, 1'b1, 3'd4, 1'b1, "n5_rotate");
      step(D_RR5, 1'b0, 8'h11, 1'b1, 1'b1, 3'd0, 1'b1, "n5_rotate_wrap");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
